zion_rf_operand_fetch: RTL

- Operand-fetch pipeline stage sitting directly upstream of the register-file read channels (rs out, dat in).
- Accepts decoded instructions, drives two read channels and applies x0-zeroing and writeback bypass.
- Tracks pending destination registers in a 32-entry scoreboard and stalls on RAW/WAW hazards.
- Registers operands into a single valid/ready output stage feeding execute.

---
 rtl/zion_rf_operand_fetch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/zion_rf_operand_fetch.sv
// Operand-fetch stage between decode and execute.
// Reads two register-file channels, zeroes x0 and bypasses same-cycle writeback.
// Tracks pending destinations in a 32-entry scoreboard and stalls on RAW/WAW hazards.
// Holds the fetched operands in a single valid/ready output register.
//
// Ports:
//   clk, rst_n                   clock and asynchronous active-low reset
//   flush                        kill the output stage and clear the scoreboard
//   in_vld/in_rdy, in_*          decoded instruction handshake and fields
//   rf_rd0_rs/rf_rd0_dat         read channel 0 (rs1); data returns combinationally
//   rf_rd1_rs/rf_rd1_dat         read channel 1 (rs2)
//   wb_vld, wb_rd, wb_dat        writeback bypass and scoreboard release
//   out_vld/out_rdy, out_*       operands and instruction info sent to execute
//   sb_busy                      at least one destination is still pending
module zion_rf_operand_fetch #(
    parameter bit          RV64   = 1'b0,
    parameter int unsigned CTRL_W = 16,
    localparam int unsigned XLEN  = 32 * (1 + int'(RV64))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_vld,
    output logic              in_rdy,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [4:0]        in_rd,
    input  logic              in_rd_wen,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic [4:0]        rf_rd0_rs,
    input  logic [XLEN-1:0]   rf_rd0_dat,
    output logic [4:0]        rf_rd1_rs,
    input  logic [XLEN-1:0]   rf_rd1_dat,
    input  logic              wb_vld,
    input  logic [4:0]        wb_rd,
    input  logic [XLEN-1:0]   wb_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [XLEN-1:0]   out_op1,
    output logic [XLEN-1:0]   out_op2,
    output logic [4:0]        out_rd,
    output logic              out_rd_wen,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic              sb_busy
);

    logic [31:0]     sb_q;
    logic [31:0]     sb_d;
    logic [XLEN-1:0] op1_d;
    logic [XLEN-1:0] op2_d;
    logic            wb_rs1;
    logic            wb_rs2;
    logic            wb_rdm;
    logic            hit_rs1;
    logic            hit_rs2;
    logic            hit_rd;
    logic            hazard;
    logic            accept;

    // Read addresses follow the decoded sources regardless of in_vld.
    assign rf_rd0_rs = in_rs1;
    assign rf_rd1_rs = in_rs2;

    assign wb_rs1 = wb_vld && (wb_rd == in_rs1);
    assign wb_rs2 = wb_vld && (wb_rd == in_rs2);
    assign wb_rdm = wb_vld && (wb_rd == in_rd);

    // Operand select: x0 reads zero, a writeback in flight beats stale RF data.
    always_comb begin
        op1_d = rf_rd0_dat;
        op2_d = rf_rd1_dat;
        if (in_rs1 == 5'd0) begin
            op1_d = '0;
        end else if (wb_rs1) begin
            op1_d = wb_dat;
        end
        if (in_rs2 == 5'd0) begin
            op2_d = '0;
        end else if (wb_rs2) begin
            op2_d = wb_dat;
        end
    end

    // A pending register being written back this cycle no longer blocks.
    assign hit_rs1 = sb_q[in_rs1] && (in_rs1 != 5'd0) && !wb_rs1;
    assign hit_rs2 = sb_q[in_rs2] && (in_rs2 != 5'd0) && !wb_rs2;
    assign hit_rd  = sb_q[in_rd]  && (in_rd  != 5'd0) && !wb_rdm;
    assign hazard  = in_vld && (hit_rs1 || hit_rs2 || (in_rd_wen && hit_rd));
    assign in_rdy  = !flush && !hazard && (!out_vld || out_rdy);
    assign accept  = in_vld && in_rdy;

    // Scoreboard next state: release on writeback, then claim on accept so a
    // same-cycle set of the same register wins; flush clears everything.
    always_comb begin
        sb_d = sb_q;
        if (wb_vld && (wb_rd != 5'd0)) begin
            sb_d[wb_rd] = 1'b0;
        end
        if (accept && in_rd_wen && (in_rd != 5'd0)) begin
            sb_d[in_rd] = 1'b1;
        end
        if (flush) begin
            sb_d = '0;
        end
    end

    // Scoreboard state and its registered summary bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q    <= '0;
            sb_busy <= 1'b0;
        end else begin
            sb_q    <= sb_d;
            sb_busy <= |sb_d;
        end
    end

    // Output stage: load on accept, drain on out_rdy, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld    <= 1'b0;
            out_op1    <= '0;
            out_op2    <= '0;
            out_rd     <= 5'd0;
            out_rd_wen <= 1'b0;
            out_ctrl   <= '0;
        end else if (flush) begin
            out_vld <= 1'b0;
        end else if (accept) begin
            out_vld    <= 1'b1;
            out_op1    <= op1_d;
            out_op2    <= op2_d;
            out_rd     <= in_rd;
            out_rd_wen <= in_rd_wen;
            out_ctrl   <= in_ctrl;
        end else if (out_rdy) begin
            out_vld <= 1'b0;
        end
    end

endmodule
